// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings and FSM states.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_abs_neg.sv
// Two's-complement conditional negate: y = neg ? -a : a.
module mdu_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = neg_i ? (~a_i + WIDTH'(1)) : a_i;

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO: one bit per cycle, start/busy handshake.
// Handshake: start is sampled only while busy=0; done pulses one cycle as HI/LO take the result.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opnd_q;
    logic                 is_div_q;
    logic                 res_neg_q;
    logic                 rem_neg_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 is_mul_op;
    logic                 is_div_op;
    logic                 signed_op;
    logic                 div_zero;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // A zero divisor skips sign handling so the restoring loop yields all-ones / raw srcA.
    always_comb begin
        is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
        is_div_op = (op == OP_DIV) || (op == OP_DIVU);
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        div_zero  = is_div_op && (srcB == '0);
        a_neg     = signed_op && srcA[WIDTH-1] && !div_zero;
        b_neg     = signed_op && srcB[WIDTH-1];
    end

    mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.a_i(srcA), .neg_i(a_neg), .y_o(mag_a));
    mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.a_i(srcB), .neg_i(b_neg), .y_o(mag_b));

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        acc_step  = acc_q;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_trial = div_shift - {1'b0, opnd_q};
        if (is_div_q) begin
            if (!div_trial[WIDTH]) begin
                acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    mdu_abs_neg #(.WIDTH(2*WIDTH)) u_fix_prod (.a_i(acc_q), .neg_i(res_neg_q), .y_o(prod_fix));
    mdu_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (.a_i(acc_q[WIDTH-1:0]), .neg_i(res_neg_q), .y_o(quo_fix));
    mdu_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (.a_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(rem_neg_q), .y_o(rem_fix));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MTHI) begin
                            hi_q <= srcA;
                        end else if (op == OP_MTLO) begin
                            lo_q <= srcA;
                        end else if (is_mul_op || is_div_op) begin
                            state_q   <= CALC;
                            busy_q    <= 1'b1;
                            cnt_q     <= '0;
                            is_div_q  <= is_div_op;
                            res_neg_q <= signed_op && (srcA[WIDTH-1] ^ srcB[WIDTH-1]) && !div_zero;
                            rem_neg_q <= a_neg;
                            opnd_q    <= is_div_op ? mag_b : mag_a;
                            acc_q     <= {{WIDTH{1'b0}}, (is_div_op ? mag_a : mag_b)};
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus randomized ops against a plain-arithmetic model.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] srcA;
    logic [W-1:0] srcB;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           total;
    int           bad;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    mdu_iter #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .op     (op),
        .srcA   (srcA),
        .srcB   (srcB),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // reference model: plain integer arithmetic on 64-bit values
    task automatic ref_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0]        ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            OP_MULT: begin
                sp = sa * sb;
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            OP_MULTU: begin
                up = ua * ub;
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            OP_DIV: begin
                if (b == 0) begin
                    m_lo = '1;
                    m_hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = '0;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    m_lo = sq[31:0];
                    m_hi = sr[31:0];
                end
            end
            OP_DIVU: begin
                if (b == 0) begin
                    m_lo = '1;
                    m_hi = a;
                end else begin
                    up = ua / ub;
                    m_lo = up[31:0];
                    up = ua % ub;
                    m_hi = up[31:0];
                end
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // driver: called at a negedge, leaves the bench at the negedge after the sampling edge
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat = 1;
        busy_n = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_check(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat, bn;
        ref_op(o, a, b);
        exp_q.push_back(m_hi);
        exp_q.push_back(m_lo);
        issue(o, a, b);
        wait_done(lat, bn);
        check("latency", 64'(lat), 64'(W + 2));
        check("busy_cycles", 64'(bn), 64'(W + 1));
        check("busy_at_done", 64'(busy), 64'd0);
        check("hi", 64'(hi), 64'(exp_q.pop_front()));
        check("lo", 64'(lo), 64'(exp_q.pop_front()));
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 6))
            0: v = '0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = W'($urandom_range(1, 15));
            4: begin
                v = W'($urandom_range(1, 15));
                v = ~v + 1;
            end
            default: v = $urandom();
        endcase
        return v;
    endfunction

    initial begin
        int lat, bn;
        logic [2:0] ro;
        total = 0;
        bad = 0;
        m_hi = '0;
        m_lo = '0;
        reset_n = 1'b0;
        start = 1'b0;
        op = '0;
        srcA = '0;
        srcB = '0;
        repeat (3) @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_check(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        check("mult_m3x7_lo", 64'(lo), 64'hFFFF_FFEB);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        run_check(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_check(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_check(OP_DIVU, 32'd7, 32'd0);
        run_check(OP_DIV, 32'hFFFF_FFF9, 32'd0);
        run_check(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_check(OP_MULT, 32'h8000_0000, 32'h8000_0000);

        // MTHI / MTLO / undefined op in idle
        @(negedge clk);
        ref_op(OP_MTHI, 32'h1234, 32'd0);
        issue(OP_MTHI, 32'h1234, 32'd0);
        check("mthi_hi", 64'(hi), 64'(m_hi));
        check("mthi_lo", 64'(lo), 64'(m_lo));
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_done", 64'(done), 64'd0);
        ref_op(OP_MTLO, 32'hCAFE_0001, 32'd0);
        issue(OP_MTLO, 32'hCAFE_0001, 32'd0);
        check("mtlo_lo", 64'(lo), 64'(m_lo));
        check("mtlo_hi", 64'(hi), 64'(m_hi));
        issue(3'b111, 32'hDEAD_BEEF, 32'd1);
        check("undef_busy", 64'(busy), 64'd0);
        check("undef_hi", 64'(hi), 64'(m_hi));
        check("undef_lo", 64'(lo), 64'(m_lo));

        // start while busy is ignored
        ref_op(OP_DIVU, 32'd100, 32'd7);
        exp_q.push_back(m_hi);
        exp_q.push_back(m_lo);
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        start = 1'b1;
        op = OP_MULTU;
        srcA = 32'd2;
        srcB = 32'd3;
        repeat (5) @(negedge clk);
        start = 1'b0;
        wait_done(lat, bn);
        check("ign_done_seen", 64'(done), 64'd1);
        check("ign_hi", 64'(hi), 64'(exp_q.pop_front()));
        check("ign_lo", 64'(lo), 64'(exp_q.pop_front()));
        @(negedge clk);
        check("ign_no_queue", 64'(busy), 64'd0);

        // back-to-back: second start lands on the done cycle
        run_check(OP_MULTU, 32'd2, 32'd3);
        run_check(OP_DIV, 32'd100, 32'hFFFF_FFF9);

        // asynchronous reset in the middle of CALC
        issue(OP_MULT, 32'h0001_2345, 32'h0000_0777);
        repeat (10) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_check(OP_MULT, 32'd5, 32'd6);
        check("mult_5x6_lo", 64'(lo), 64'd30);

        // randomized arithmetic ops, occasionally interleaved with MTHI/MTLO
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 3));
            run_check(ro, pick(), pick());
            if ($urandom_range(0, 4) == 0) begin
                ro = ($urandom_range(0, 1) == 0) ? OP_MTHI : OP_MTLO;
                srcA = $urandom();
                ref_op(ro, srcA, 32'd0);
                issue(ro, srcA, 32'd0);
                check("rnd_mt_hi", 64'(hi), 64'(m_hi));
                check("rnd_mt_lo", 64'(lo), 64'(m_lo));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
